// File: rtl/ripple_count_sampler.sv
// ----------------------------------------------------------------------------
// ripple_count_sampler
//
// Samples the 4-bit output of an asynchronous ripple counter into the clk
// domain. The raw value is synchronized, then a value is accepted only after
// it has been stable for STABLE_CYCLES synchronized samples. Accepted values
// go out through a valid/ready holding register. An unconsumed value that
// gets overwritten raises a sticky overrun flag.
//
// Optional feature (macro RIPPLE_SAMPLER_WRAP_EXT_EN):
//   defined   - each accepted value numerically below the previously accepted
//               one counts as a counter wrap. ext_count counts wraps mod 256.
//   undefined - no wrap logic is built and ext_count is tied to 0.
//
// Parameters:
//   STABLE_CYCLES  consecutive equal synchronized samples to accept (1..15)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   q_in       [3:0] raw ripple-counter value, asynchronous, may glitch
//   out_ready  consumer takes count_out at an edge where out_valid=1
//   count_out  [3:0] last accepted stable value
//   out_valid  count_out holds a new, unconsumed value
//   ext_count  [7:0] number of wraps seen (0 when the feature is off)
//   overrun    sticky: an unconsumed value was overwritten
// ----------------------------------------------------------------------------
module ripple_count_sampler #(
    parameter int STABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] q_in,
    input  logic       out_ready,
    output logic [3:0] count_out,
    output logic       out_valid,
    output logic [7:0] ext_count,
    output logic       overrun
);

    localparam logic [3:0] ACC_AT = 4'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_ACCEPT} state_t;

    state_t     state, nstate;
    logic [3:0] s1, s2;
    logic [3:0] stab;
    logic [3:0] last;
    logic [3:0] cand;
    logic       load;

    // Two-flop synchronizer and stability counter. The counter restarts on
    // the edge where s2 takes a new value, so after k stable edges it reads
    // k-1 and then saturates at 15.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            stab <= '0;
        end else begin
            s1 <= q_in;
            s2 <= s1;
            if (s1 != s2)
                stab <= '0;
            else if (stab != 4'hF)
                stab <= stab + 4'd1;
        end
    end

    // Candidate is the s2 value that qualified on the edge entering ACCEPT.
    // Holding it through ACCEPT keeps a change of s2 during the load cycle
    // from sneaking an unqualified value into count_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cand <= '0;
        else if (state != S_ACCEPT)
            cand <= s2;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_WAIT;
        else
            state <= nstate;
    end

    // FSM: next state. WAIT may go straight to ACCEPT so that
    // STABLE_CYCLES=1 qualifies on the first sample without a SETTLE cycle.
    always_comb begin
        nstate = state;
        case (state)
            S_WAIT, S_SETTLE: begin
                if (s2 == last)
                    nstate = S_WAIT;
                else if (stab == ACC_AT)
                    nstate = S_ACCEPT;
                else
                    nstate = S_SETTLE;
            end
            S_ACCEPT: nstate = S_WAIT;
            default:  nstate = S_WAIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        load = (state == S_ACCEPT);
    end

    // Output holding register with valid/ready and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= '0;
            count_out <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (load) begin
            last      <= cand;
            count_out <= cand;
            out_valid <= 1'b1;
            if (out_valid && !out_ready)
                overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RIPPLE_SAMPLER_WRAP_EXT_EN
    logic [7:0] ext_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ext_r <= '0;
        else if (load && (cand < last))
            ext_r <= ext_r + 8'd1;
    end

    assign ext_count = ext_r;
`else
    assign ext_count = 8'd0;
`endif

endmodule

// File: tb/tb_ripple_count_sampler.sv
// ----------------------------------------------------------------------------
// Testbench for ripple_count_sampler (default STABLE_CYCLES=2).
// Inputs change and outputs are sampled on the falling edge of clk.
// ----------------------------------------------------------------------------
module tb_ripple_count_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] q_in;
    logic       out_ready;
    logic [3:0] count_out;
    logic       out_valid;
    logic [7:0] ext_count;
    logic       overrun;

    int passed = 0;
    int total  = 0;

    ripple_count_sampler #(.STABLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_in      (q_in),
        .out_ready (out_ready),
        .count_out (count_out),
        .out_valid (out_valid),
        .ext_count (ext_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] q;
        logic       rdy;
        int         hold;
        logic [3:0] exp_cnt;
        logic       exp_vld;
        logic       exp_ovr;
        logic [7:0] exp_wraps;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [7:0] ext_exp(input logic [7:0] wraps);
`ifdef RIPPLE_SAMPLER_WRAP_EXT_EN
        return wraps;
`else
        return 8'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Watch out_valid for n cycles; returns 1 if it was ever seen high.
    task automatic watch_valid(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
    endtask

    initial begin
        logic seen;

        // Steps after the first acceptance of 5. Accepted sequence is
        // 5,3,9,14,15,2: wraps at 5->3 and 15->2.
        vecs[0] = '{4'd3,  1'b0, 10, 4'd3,  1'b1, 1'b0, 8'd1};
        vecs[1] = '{4'd9,  1'b0, 10, 4'd9,  1'b1, 1'b1, 8'd1};
        vecs[2] = '{4'd9,  1'b1, 2,  4'd9,  1'b0, 1'b1, 8'd1};
        vecs[3] = '{4'd14, 1'b1, 10, 4'd14, 1'b0, 1'b1, 8'd1};
        vecs[4] = '{4'd15, 1'b1, 10, 4'd15, 1'b0, 1'b1, 8'd1};
        vecs[5] = '{4'd2,  1'b1, 10, 4'd2,  1'b0, 1'b1, 8'd2};

        // Reset state
        rst = 1'b1; q_in = 4'd0; out_ready = 1'b1;
        cycles(2);
        check("rst_count_out", 8'(count_out), 8'd0);
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_overrun",   8'(overrun),   8'd0);
        check("rst_ext_count", ext_count,     8'd0);

        // q_in=0 after release must not produce a value
        rst = 1'b0;
        watch_valid(10, seen);
        check("zero_no_valid", 8'(seen), 8'd0);

        // 0->5: valid appears exactly after the 5th falling edge (edge N+4)
        q_in = 4'd5;
        watch_valid(4, seen);
        check("lat_early_valid", 8'(seen), 8'd0);
        cycles(1);
        check("lat_valid",     8'(out_valid), 8'd1);
        check("lat_count_out", 8'(count_out), 8'd5);
        check("lat_overrun",   8'(overrun),   8'd0);
        cycles(1);
        check("lat_pulse_end", 8'(out_valid), 8'd0);

        // One-cycle glitch 5->7->5 is filtered
        q_in = 4'd7;
        cycles(1);
        q_in = 4'd5;
        watch_valid(10, seen);
        check("glitch_no_valid",  8'(seen),      8'd0);
        check("glitch_count_out", 8'(count_out), 8'd5);

        // Table-driven steps: overrun, consumption, wraps
        for (int i = 0; i < 6; i++) begin
            q_in = vecs[i].q;
            out_ready = vecs[i].rdy;
            cycles(vecs[i].hold);
            check($sformatf("vec%0d_count_out", i), 8'(count_out), 8'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_out_valid", i), 8'(out_valid), 8'(vecs[i].exp_vld));
            check($sformatf("vec%0d_overrun",   i), 8'(overrun),   8'(vecs[i].exp_ovr));
            check($sformatf("vec%0d_ext_count", i), ext_count,     ext_exp(vecs[i].exp_wraps));
        end

        // Asynchronous reset between edges while out_valid=1 and overrun=1
        out_ready = 1'b0;
        q_in = 4'd4;
        cycles(6);
        check("pre_rst_valid", 8'(out_valid), 8'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid",     8'(out_valid), 8'd0);
        check("async_rst_count_out", 8'(count_out), 8'd0);
        check("async_rst_overrun",   8'(overrun),   8'd0);
        check("async_rst_ext_count", ext_count,     8'd0);
        q_in = 4'd0;
        #1 rst = 1'b0;
        cycles(2);

        // Acceptance and consumption on the same edge
        q_in = 4'd3;
        cycles(10);
        check("sim_pre_valid", 8'(out_valid), 8'd1);
        q_in = 4'd6;
        cycles(4);
        check("sim_hold_count", 8'(count_out), 8'd3);
        out_ready = 1'b1;
        cycles(1);
        check("sim_valid",     8'(out_valid), 8'd1);
        check("sim_count_out", 8'(count_out), 8'd6);
        check("sim_overrun",   8'(overrun),   8'd0);
        cycles(1);
        check("sim_consumed",  8'(out_valid), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
